// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared types and constants for the multi-channel I2C master:
//             transaction state encoding, SCL quarter-phase codes and the
//             bit-count limit used by the address and data shifters.
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Transaction phases; each non-idle state lasts a whole number of bits
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_AACK  = 3'd3,
    ST_DATA  = 3'd4,
    ST_DACK  = 3'd5,
    ST_STOP  = 3'd6
  } state_t;

  // Quarter phases within one bit period
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Index of the final bit of an 8-bit address or data byte
  localparam logic [2:0] LAST_BIT = 3'd7;

endpackage
`default_nettype wire

// File: rtl/i2c_multi_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_multi_master_if
//  Purpose  : Client request/response bundle plus open-drain pad controls
//             for the multi-channel I2C master.
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_multi_master_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]   req;
  logic [7*NUM_CH-1:0] addr;
  logic [NUM_CH-1:0]   rw;
  logic [8*NUM_CH-1:0] wdata;
  logic [NUM_CH-1:0]   grant;
  logic                done;
  logic [2:0]          done_ch;
  logic                ack_err;
  logic [7:0]          rdata;
  logic                busy;
  logic                scl_oe;
  logic                sda_oe;
  logic                sda_i;

  // The I2C master core side
  modport master (
    input  req, addr, rw, wdata, sda_i,
    output grant, done, done_ch, ack_err, rdata, busy, scl_oe, sda_oe
  );

  // Clients and pads side
  modport slave (
    output req, addr, rw, wdata, sda_i,
    input  grant, done, done_ch, ack_err, rdata, busy, scl_oe, sda_oe
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin picker. Chooses the first requesting channel at or
//             after the pointer (wrapping) and moves the pointer past the
//             winner when the advance strobe is given.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [2:0]        grant_idx,
  output logic              valid
);

  logic [PW-1:0] pointer;
  logic [PW-1:0] next_ptr;
  int            pos;

  // Search channels in rotated order starting at the pointer
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    next_ptr  = '0;
    pos       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos = int'(pointer) + k;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!valid && (j == pos) && req[j]) begin
          valid     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = 3'(j);
          next_ptr  = (j + 1 >= NUM_CH) ? '0 : PW'(j + 1);
        end
      end
    end
  end

  // Pointer moves to winner+1 only when the winner is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer <= '0;
    end else if (advance && valid) begin
      pointer <= next_ptr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_multi_master.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_multi_master
//  Purpose  : Shared I2C master serving NUM_CH requesters. Runs one
//             single-byte write or read at a time with slave-ACK checking,
//             divided SCL (4*QDIV clk per bit) and per-channel completion.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_multi_master
  import i2c_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int QDIV   = 125
) (
  input logic                clk,
  input logic                reset,
  i2c_multi_master_if.master bus
);

  localparam int            QW    = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  state_t            state, state_nxt;
  logic [QW-1:0]     qcnt, qcnt_nxt;
  logic [1:0]        qph, qph_nxt;
  logic [2:0]        bitcnt, bitcnt_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic [7:0]        wbyte, wbyte_nxt;
  logic              cur_rw, cur_rw_nxt;
  logic [2:0]        cur_ch, cur_ch_nxt;
  logic              err, err_nxt;
  logic [NUM_CH-1:0] gnt, gnt_nxt;
  logic              done_r, done_nxt;
  logic [2:0]        done_ch_r, done_ch_nxt;
  logic              ack_err_r, ack_err_nxt;
  logic [7:0]        rdata_r, rdata_nxt;
  logic              scl_drv, sda_drv;

  logic              q_end, sample_pt, bit_end;
  logic [NUM_CH-1:0] arb_grant;
  logic [2:0]        arb_idx;
  logic              arb_valid;
  logic              advance;
  logic [6:0]        sel_addr;
  logic              sel_rw;
  logic [7:0]        sel_wdata;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req),
    .advance   (advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign q_end     = (qcnt == QLAST);
  assign sample_pt = q_end && (qph == Q1);
  assign bit_end   = q_end && (qph == Q3);

  // Pick the winning channel's transaction fields
  always_comb begin
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = bus.addr[7*i +: 7];
        sel_rw    = bus.rw[i];
        sel_wdata = bus.wdata[8*i +: 8];
      end
    end
  end

  // Next-state, shifter and pad-drive decode
  always_comb begin
    state_nxt   = state;
    qcnt_nxt    = qcnt;
    qph_nxt     = qph;
    bitcnt_nxt  = bitcnt;
    shreg_nxt   = shreg;
    wbyte_nxt   = wbyte;
    cur_rw_nxt  = cur_rw;
    cur_ch_nxt  = cur_ch;
    err_nxt     = err;
    gnt_nxt     = gnt;
    done_nxt    = 1'b0;
    done_ch_nxt = done_ch_r;
    ack_err_nxt = ack_err_r;
    rdata_nxt   = rdata_r;
    advance     = 1'b0;
    scl_drv     = 1'b0;
    sda_drv     = 1'b0;

    if (state != ST_IDLE) begin
      if (q_end) begin
        qcnt_nxt = '0;
        qph_nxt  = qph + 2'd1;
      end else begin
        qcnt_nxt = qcnt + 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          advance    = 1'b1;
          gnt_nxt    = arb_grant;
          cur_ch_nxt = arb_idx;
          cur_rw_nxt = sel_rw;
          wbyte_nxt  = sel_wdata;
          shreg_nxt  = {sel_addr, sel_rw};
          err_nxt    = 1'b0;
          qcnt_nxt   = '0;
          qph_nxt    = Q0;
          bitcnt_nxt = '0;
          state_nxt  = ST_START;
        end
      end
      ST_START: begin
        scl_drv = (qph == Q3);
        sda_drv = (qph == Q2) || (qph == Q3);
        if (bit_end) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        scl_drv = (qph == Q0) || (qph == Q3);
        sda_drv = ~shreg[7];
        if (bit_end) begin
          shreg_nxt = {shreg[6:0], 1'b0};
          if (bitcnt == LAST_BIT) state_nxt = ST_AACK;
          else bitcnt_nxt = bitcnt + 3'd1;
        end
      end
      ST_AACK: begin
        scl_drv = (qph == Q0) || (qph == Q3);
        if (sample_pt && bus.sda_i) err_nxt = 1'b1;
        if (bit_end) begin
          bitcnt_nxt = '0;
          shreg_nxt  = cur_rw ? 8'h00 : wbyte;
          state_nxt  = err ? ST_STOP : ST_DATA;
        end
      end
      ST_DATA: begin
        scl_drv = (qph == Q0) || (qph == Q3);
        sda_drv = ~cur_rw & ~shreg[7];
        if (cur_rw && sample_pt) shreg_nxt = {shreg[6:0], bus.sda_i};
        if (bit_end) begin
          if (!cur_rw) shreg_nxt = {shreg[6:0], 1'b0};
          if (bitcnt == LAST_BIT) state_nxt = ST_DACK;
          else bitcnt_nxt = bitcnt + 3'd1;
        end
      end
      ST_DACK: begin
        // A read ends with a master NACK: SDA simply stays released
        scl_drv = (qph == Q0) || (qph == Q3);
        if (!cur_rw && sample_pt && bus.sda_i) err_nxt = 1'b1;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        scl_drv = (qph == Q0);
        sda_drv = (qph == Q0) || (qph == Q1);
        if (bit_end) begin
          state_nxt   = ST_IDLE;
          gnt_nxt     = '0;
          done_nxt    = 1'b1;
          done_ch_nxt = cur_ch;
          ack_err_nxt = err;
          if (cur_rw && !err) rdata_nxt = shreg;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      qcnt      <= '0;
      qph       <= Q0;
      bitcnt    <= '0;
      shreg     <= '0;
      wbyte     <= '0;
      cur_rw    <= 1'b0;
      cur_ch    <= '0;
      err       <= 1'b0;
      gnt       <= '0;
      done_r    <= 1'b0;
      done_ch_r <= '0;
      ack_err_r <= 1'b0;
      rdata_r   <= '0;
    end else begin
      state     <= state_nxt;
      qcnt      <= qcnt_nxt;
      qph       <= qph_nxt;
      bitcnt    <= bitcnt_nxt;
      shreg     <= shreg_nxt;
      wbyte     <= wbyte_nxt;
      cur_rw    <= cur_rw_nxt;
      cur_ch    <= cur_ch_nxt;
      err       <= err_nxt;
      gnt       <= gnt_nxt;
      done_r    <= done_nxt;
      done_ch_r <= done_ch_nxt;
      ack_err_r <= ack_err_nxt;
      rdata_r   <= rdata_nxt;
    end
  end

  assign bus.grant   = gnt;
  assign bus.done    = done_r;
  assign bus.done_ch = done_ch_r;
  assign bus.ack_err = ack_err_r;
  assign bus.rdata   = rdata_r;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.scl_oe  = scl_drv;
  assign bus.sda_oe  = sda_drv;

endmodule
`default_nettype wire

// File: tb/tb_i2c_multi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_multi_master
//  Purpose  : Directed self-checking bench for i2c_multi_master with a small
//             I2C slave model on the two-channel instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_multi_master;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  i2c_multi_master_if #(.NUM_CH(2)) bus2 ();
  i2c_multi_master_if #(.NUM_CH(4)) bus4 ();

  i2c_multi_master #(.NUM_CH(2), .QDIV(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  i2c_multi_master #(.NUM_CH(4), .QDIV(1)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // Slave model state (two-channel bus)
  logic       slv_low;
  logic       slv_ack;
  logic [7:0] slv_rbyte;
  logic       scl_p, sda_p;
  logic       scl_line, sda_line;
  int         rises = 0, falls = 0, stop_cnt = 0, stop_rises = 0, done_cnt = 0;
  logic [7:0] cap_addr = '0, cap_data = '0;
  logic       cap_aack = 1'b0, cap_dack = 1'b0;

  assign bus2.sda_i = ~(bus2.sda_oe | slv_low);
  assign bus4.sda_i = ~bus4.sda_oe;
  assign scl_line   = ~bus2.scl_oe;
  assign sda_line   = bus2.sda_i;

  // Bus monitor and responding slave, evaluated away from the DUT clock edge
  always @(negedge clk) begin
    if (bus2.done) done_cnt <= done_cnt + 1;
    if (reset) begin
      slv_low <= 1'b0;
      scl_p   <= 1'b1;
      sda_p   <= 1'b1;
    end else begin
      scl_p <= scl_line;
      sda_p <= sda_line;
      if (scl_p && scl_line && sda_p && !sda_line) begin
        rises <= 0;
        falls <= 0;
      end else if (scl_p && scl_line && !sda_p && sda_line) begin
        stop_cnt   <= stop_cnt + 1;
        stop_rises <= rises;
      end else if (!scl_p && scl_line) begin
        rises <= rises + 1;
        if (rises < 8)        cap_addr <= {cap_addr[6:0], sda_line};
        else if (rises == 8)  cap_aack <= sda_line;
        else if (rises < 17)  cap_data <= {cap_data[6:0], sda_line};
        else if (rises == 17) cap_dack <= sda_line;
      end else if (scl_p && !scl_line) begin
        falls <= falls + 1;
        if (falls == 8)                     slv_low <= slv_ack;
        else if (falls >= 9 && falls <= 16) slv_low <= cap_addr[0] & ~slv_rbyte[16 - falls];
        else if (falls == 17)               slv_low <= ~cap_addr[0] & slv_ack;
        else                                slv_low <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant2(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus2.grant == '0 && n < 50);
  endtask

  task automatic wait_done2(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus2.done && n < 400);
  endtask

  task automatic wait_grant4(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus4.grant == '0 && n < 50);
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus4.done && n < 200);
  endtask

  initial begin
    int n, sc, dc;
    logic [1:0] exp_g;
    reset = 1'b1;
    slv_ack = 1'b1; slv_rbyte = 8'h00;
    bus2.req = '0; bus2.addr = '0; bus2.rw = '0; bus2.wdata = '0;
    bus4.req = '0; bus4.addr = '0; bus4.rw = '0; bus4.wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_grant",   bus2.grant,   0);
    check("rst_done",    bus2.done,    0);
    check("rst_done_ch", bus2.done_ch, 0);
    check("rst_ack_err", bus2.ack_err, 0);
    check("rst_rdata",   bus2.rdata,   0);
    check("rst_busy",    bus2.busy,    0);
    check("rst_scl_oe",  bus2.scl_oe,  0);
    check("rst_sda_oe",  bus2.sda_oe,  0);
    check("rst_grant4",  bus4.grant,   0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ch0 write 0x45 <- 0x66, slave ACKs
    bus2.addr = {7'h47, 7'h45}; bus2.rw = 2'b00; bus2.wdata = {8'h3C, 8'h66};
    sc = stop_cnt;
    bus2.req = 2'b01;
    wait_grant2(n);
    check("w_grant_lat", n, 1);
    check("w_grant", bus2.grant, 2'b01);
    check("w_busy", bus2.busy, 1);
    bus2.req = 2'b00;
    wait_done2(n);
    check("w_cycles", n, 160);
    check("w_done_ch", bus2.done_ch, 0);
    check("w_ack_err", bus2.ack_err, 0);
    check("w_grant_end", bus2.grant, 0);
    check("w_busy_end", bus2.busy, 0);
    check("w_addr_byte", cap_addr, 8'h8A);
    check("w_data_byte", cap_data, 8'h66);
    check("w_aack", cap_aack, 0);
    check("w_stop", stop_cnt, sc + 1);
    check("w_stop_rises", stop_rises, 19);
    @(negedge clk);
    check("w_done_pulse", bus2.done, 0);
    check("w_idle_scl", bus2.scl_oe, 0);
    check("w_idle_sda", bus2.sda_oe, 0);

    // ch1 read 0x47, slave returns 0xA5
    bus2.rw = 2'b10; slv_rbyte = 8'hA5;
    bus2.req = 2'b10;
    wait_grant2(n);
    check("r_grant_lat", n, 1);
    check("r_grant", bus2.grant, 2'b10);
    bus2.req = 2'b00;
    wait_done2(n);
    check("r_cycles", n, 160);
    check("r_done_ch", bus2.done_ch, 1);
    check("r_ack_err", bus2.ack_err, 0);
    check("r_rdata", bus2.rdata, 8'hA5);
    check("r_addr_byte", cap_addr, 8'h8F);
    check("r_master_nack", cap_dack, 1);

    // ch0 write, no slave present: address NACK
    bus2.rw = 2'b00; slv_ack = 1'b0;
    sc = stop_cnt;
    @(negedge clk);
    bus2.req = 2'b01;
    wait_grant2(n);
    check("n_grant", bus2.grant, 2'b01);
    bus2.req = 2'b00;
    wait_done2(n);
    check("n_cycles", n, 88);
    check("n_ack_err", bus2.ack_err, 1);
    check("n_done_ch", bus2.done_ch, 0);
    check("n_rdata_hold", bus2.rdata, 8'hA5);
    check("n_aack", cap_aack, 1);
    check("n_stop", stop_cnt, sc + 1);
    check("n_stop_rises", stop_rises, 10);

    // Reset during DATA bit 3
    slv_ack = 1'b1;
    @(negedge clk);
    bus2.req = 2'b01;
    wait_grant2(n);
    bus2.req = 2'b00;
    repeat (100) @(negedge clk);
    check("x_busy_mid", bus2.busy, 1);
    dc = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("x_scl_oe", bus2.scl_oe, 0);
    check("x_sda_oe", bus2.sda_oe, 0);
    check("x_busy", bus2.busy, 0);
    check("x_grant", bus2.grant, 0);
    check("x_rdata", bus2.rdata, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("x_no_done", done_cnt, dc);

    // Both channels requesting continuously: strict alternation
    bus2.addr = {7'h22, 7'h45}; bus2.rw = 2'b00; bus2.wdata = {8'h3C, 8'h66};
    bus2.req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
      wait_grant2(n);
      check("rr_grant_lat", n, 1);
      check("rr_grant", bus2.grant, exp_g);
      if (t == 3) bus2.req = 2'b00;
      wait_done2(n);
      check("rr_cycles", n, 160);
      check("rr_done_ch", bus2.done_ch, (t % 2 == 1) ? 1 : 0);
      check("rr_grant_end", bus2.grant, 0);
      check("rr_data", cap_data, (t % 2 == 1) ? 8'h3C : 8'h66);
    end
    check("rr_rdata_hold", bus2.rdata, 0);

    // Four channels, QDIV=1: move pointer to 3, then 1010 serves ch3 then ch1
    bus4.addr = {7'h33, 7'h22, 7'h11, 7'h10};
    bus4.req  = 4'b0100;
    wait_grant4(n);
    check("c4_grant2", bus4.grant, 4'b0100);
    bus4.req = 4'b0000;
    wait_done4(n);
    check("c4_cycles", n, 44);
    check("c4_done_ch2", bus4.done_ch, 2);
    check("c4_ack_err", bus4.ack_err, 1);
    bus4.req = 4'b1010;
    wait_grant4(n);
    check("c4_grant_lat", n, 1);
    check("c4_grant3", bus4.grant, 4'b1000);
    wait_done4(n);
    check("c4_done_ch3", bus4.done_ch, 3);
    wait_grant4(n);
    check("c4_grant1", bus4.grant, 4'b0010);
    bus4.req = 4'b0000;
    wait_done4(n);
    check("c4_done_ch1", bus4.done_ch, 1);
    @(negedge clk);
    check("c4_idle_busy", bus4.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_multi_master.md
# i2c_multi_master

Parametrised I2C master that serves NUM_CH independent requesters through a built-in round-robin arbiter and runs one complete single-byte write or read transaction at a time on a shared open-drain bus. It replaces the fixed-address, free-running, two-master arrangement with divided SCL, real slave-ACK checking and per-channel completion status. It sits between the on-chip clients (LED/seven-segment/LCD controllers) and the board I2C pads.

## Interface
- NUM_CH, 2: number of requesting channels (1..8)
- QDIV, 125: clk cycles per SCL quarter-period (>=1); one bit = 4*QDIV cycles

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  NUM_CH  per-channel request level, held until that channel's done
- addr  in  7*NUM_CH  slave address per channel, channel i at [7i+6:7i]
- rw  in  NUM_CH  0 = write, 1 = read
- wdata  in  8*NUM_CH  write byte per channel
- grant  out  NUM_CH  one-hot, channel being served; 0 when idle
- done  out  1  one-cycle pulse at end of transaction
- done_ch  out  3  index of finished channel, valid with done
- ack_err  out  1  valid with done; 1 = slave NACKed address or write data
- rdata  out  8  read byte, valid with done for a read
- busy  out  1  high from grant until done
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- sda_i  in  1  sampled SDA pad

## Operation
- Reset: grant=0, done=0, done_ch=0, ack_err=0, rdata=0, busy=0, scl_oe=0, sda_oe=0, state IDLE, arbiter pointer=0, quarter counter=0.
- IDLE: if any req, arbiter picks first set bit at or after pointer (wrapping); latches addr/rw/wdata of that channel; grant/busy set next cycle; pointer moves to winner+1 mod NUM_CH. req sampled only in IDLE.
- States: IDLE, START, ADDR, AACK, DATA, DACK, STOP.
- START (1 bit): SDA released q0, SCL high q1, SDA low q2, SCL low q3.
- ADDR: 8 bits, {addr[6:0], rw}, MSB first.
- AACK: SDA released; sda_i sampled end of q1. 1 -> ack_err=1, go STOP (data phase skipped).
- DATA: write shifts wdata MSB first; read releases SDA and samples sda_i end of q1 into shift register MSB first.
- DACK: write -> sample slave ACK as AACK, NACK sets ack_err; read -> master drives NACK (SDA released).
- STOP (1 bit): SDA low q0, SCL high q1, SDA released q2, SCL high q3; then done pulse, grant=0, busy=0, back to IDLE.
- Data bits: SDA changes only in q0 (SCL low); SCL released q1-q2, pulled low q0 and q3.
- Bus idle: scl_oe=0, sda_oe=0.

## Timing
- Bit period exactly 4*QDIV clk; quarter counter wraps QDIV-1 -> 0.
- Full transaction: 20 bit periods = 80*QDIV clk from first grant cycle to done.
- Address NACK: 11 bit periods (START, 8, AACK, STOP) = 44*QDIV clk.
- Next transaction may grant the cycle after done.
- req dropped mid-transaction: ignored, transaction completes.
- Reset mid-transaction: all outputs to reset values next edge, bus released, no done pulse.
- rdata holds last read value until next read completes.

## Structure
- Package i2c_pkg: state enum, quarter-phase constants, transaction bit-count constants.
- Sub-module rr_arbiter (NUM_CH param, req, advance strobe, one-hot grant, pointer); core FSM and bit shifter in top.

## Test plan
- QDIV=2, ch0 write addr 0x45 data 0x66, slave ACKs -> SDA bytes 0x8A then 0x66, done at 160 clk, done_ch=0, ack_err=0.
- ch1 read addr 0x47, slave drives 0xA5 -> address byte 0x8F, rdata=0xA5, master NACK, done_ch=1.
- ch0 write, no slave (sda_i=1) -> ack_err=1, STOP right after AACK, done at 88 clk.
- req=2'b11 held -> service order ch0, ch1, ch0, ch1; each grant one-hot, no overlap.
- Reset asserted during DATA bit 3 -> scl_oe=sda_oe=0, busy=0 next cycle, no done; next req runs normally.
- NUM_CH=4, QDIV=1, req=4'b1010 with pointer=3 -> ch3 then ch1 served.
